// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Buffered UART receive front-end. Drains bytes from uart_rx
//                through a ready/ack handshake into a power-of-two FIFO and
//                exposes DATA / STATUS / CTRL registers to the CPU bus.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    input  logic        sel,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [3:0]  addr_ofs,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam int                  c_depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_count_full = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [3:0]          c_ofs_data   = 4'h0;
    localparam logic [3:0]          c_ofs_status = 4'h4;
    localparam logic [3:0]          c_ofs_ctrl   = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    logic [7:0]            r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overrun;

    logic        w_empty;
    logic        w_full;
    logic        w_rd_acc;
    logic        w_wr_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_ovr_set;
    logic        w_flush;
    logic        w_clr_ovr;
    logic [7:0]  w_count8;
    logic [31:0] w_status;
    logic        w_unused_bits;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_count_full);

    // A simultaneous read and write is treated as a read only.
    assign w_rd_acc = sel & rd_en;
    assign w_wr_acc = sel & wr_en & ~rd_en;

    assign w_pop     = w_rd_acc & (addr_ofs == c_ofs_data) & ~w_empty;
    assign w_flush   = w_wr_acc & (addr_ofs == c_ofs_ctrl) & wr_data[0];
    assign w_clr_ovr = w_wr_acc & (addr_ofs == c_ofs_ctrl) & wr_data[1];

    // The TAKE cycle carries the byte; a flush in that cycle drops it silently.
    // A pop in the same cycle frees a slot, so a full FIFO still accepts it.
    assign w_push    = (r_state == ST_TAKE);
    assign w_push_ok = w_push & ~w_flush & (~w_full | w_pop);
    assign w_ovr_set = w_push & ~w_flush & w_full & ~w_pop;

    assign w_count8 = 8'(r_count);
    assign w_status = {16'h0, w_count8, 5'b0, r_overrun, w_full, ~w_empty};

    assign w_unused_bits = ^wr_data[31:2];

    assign irq = ~w_empty;

    // Ingress handshake: one ack per byte, then wait for uart_rx to drop ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            rx_ack  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    rx_ack <= 1'b0;
                    if (rx_ready) begin
                        r_state <= ST_TAKE;
                        rx_ack  <= 1'b1;
                    end
                end
                ST_TAKE: begin
                    rx_ack  <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    rx_ack <= 1'b0;
                    if (!rx_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    rx_ack  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte storage; contents are don't-care until the matching count says so.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Pointers and occupancy; flush has priority over any push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun; a fresh overrun event wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (w_clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    // Registered read data, held between selected reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (w_rd_acc) begin
            case (addr_ofs)
                c_ofs_data:   rd_data <= w_empty ? 32'h0 : {23'h0, 1'b1, r_mem[r_rd_ptr]};
                c_ofs_status: rd_data <= w_status;
                default:      rd_data <= 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Scoreboard bench for uart_rx_fifo with a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_depth = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_ack;
    logic        sel = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  addr_ofs = 4'h0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] rd_data;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    // Reference model: the FIFO is a plain queue plus a sticky flag.
    logic [7:0]  mq[$];
    logic        movr = 1'b0;
    logic [31:0] last_rd = 32'h0;
    logic [31:0] expq[$];
    logic        mon_rd = 1'b0;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_ack   (rx_ack),
        .sel      (sel),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr_ofs (addr_ofs),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every selected read presents a value after the sampling edge.
    always @(posedge clk) mon_rd <= sel && rd_en && rst_n;

    always @(negedge clk) begin
        if (rx_ack) ack_cnt++;
        if (mon_rd) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected actual=%h required=none", rd_data);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL rd_data actual=%h required=%h", rd_data, e);
                end
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [3:0] ofs);
        logic [7:0] cnt;
        cnt = 8'(mq.size());
        if (ofs == 4'h0) return (mq.size() != 0) ? {23'h0, 1'b1, mq[0]} : 32'h0;
        if (ofs == 4'h4) return {16'h0, cnt, 5'b0, movr, mq.size() == c_depth, mq.size() != 0};
        return 32'h0;
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (mq.size() < c_depth) mq.push_back(b);
        else movr = 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a selected read; the expected value goes to the scoreboard.
    function automatic void issue_read(input logic [3:0] ofs);
        logic [31:0] e;
        sel = 1'b1; rd_en = 1'b1; addr_ofs = ofs;
        e = m_read(ofs);
        expq.push_back(e);
        last_rd = e;
        if (ofs == 4'h0 && mq.size() != 0) void'(mq.pop_front());
    endfunction

    task automatic bus_read(input logic [3:0] ofs);
        issue_read(ofs);
        tick;
        sel = 1'b0; rd_en = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] ofs, input logic [31:0] d);
        sel = 1'b1; wr_en = 1'b1; addr_ofs = ofs; wr_data = d;
        if (ofs == 4'h8) begin
            if (d[0]) mq.delete();
            if (d[1]) movr = 1'b0;
        end
        tick;
        sel = 1'b0; wr_en = 1'b0;
    endtask

    // mode 0: plain byte; 1: DATA read during TAKE; 2: flush+clear during TAKE
    task automatic send_byte(input logic [7:0] b, input int mode);
        int a0;
        bit seen;
        tick;
        rx_ready = 1'b1; rx_data = b; a0 = ack_cnt; seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (rx_ack) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL ack_timeout actual=0 required=1");
            rx_ready = 1'b0;
            return;
        end
        if (mode == 1) begin
            issue_read(4'h0);
            m_push(b);
        end else if (mode == 2) begin
            sel = 1'b1; wr_en = 1'b1; addr_ofs = 4'h8; wr_data = 32'h3;
            mq.delete(); movr = 1'b0;
        end else begin
            m_push(b);
        end
        tick;
        sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0; rx_ready = 1'b0;
        tick;
        check("ack_pulses", 32'(ack_cnt - a0), 32'd1);
        check("irq_after_push", {31'h0, irq}, {31'h0, mq.size() != 0});
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_ack", {31'h0, rx_ack}, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        tick; tick;
        rst_n = 1'b1;
        tick;
        bus_read(4'h4);

        // Single byte
        send_byte(8'h5A, 0);
        bus_read(4'h4);
        check("single_status_model", m_read(4'h4), 32'h0000_0101);
        bus_read(4'h0);
        bus_read(4'h4);
        check("single_irq_clear", {31'h0, irq}, 32'h0);

        // Fill and overrun
        for (int i = 0; i <= 16; i++) send_byte(8'(i), 0);
        check("fill_status_model", m_read(4'h4), 32'h0000_1007);
        bus_read(4'h4);
        for (int i = 0; i < 17; i++) bus_read(4'h0);
        bus_write(4'h8, 32'h2);

        // Wrap and simultaneous push/pop
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
        for (int i = 0; i < 10; i++) bus_read(4'h0);
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        bus_read(4'h4);
        send_byte(8'hC3, 1);
        check("full_simul_model", m_read(4'h4), 32'h0000_1003);
        bus_read(4'h4);
        for (int i = 0; i < 16; i++) bus_read(4'h0);
        send_byte(8'h77, 1);
        bus_read(4'h4);
        bus_read(4'h0);

        // CTRL: 5 queued with overrun, then clear all
        for (int i = 0; i < 17; i++) send_byte(8'($urandom), 0);
        for (int i = 0; i < 11; i++) bus_read(4'h0);
        bus_read(4'h4);
        bus_write(4'h8, 32'h3);
        bus_read(4'h4);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 2);
        bus_read(4'h4);

        // Empty read, bad offset, ignored writes, unselected access
        bus_read(4'h0);
        bus_read(4'hC);
        send_byte(8'h44, 0);
        bus_write(4'h0, 32'h3);
        bus_write(4'h4, 32'h3);
        sel = 1'b1; rd_en = 1'b1; wr_en = 1'b1; addr_ofs = 4'h8; wr_data = 32'h1;
        expq.push_back(32'h0); last_rd = 32'h0;
        tick;
        sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        bus_read(4'h4);
        rd_en = 1'b1; addr_ofs = 4'h0;
        tick; tick;
        rd_en = 1'b0;
        check("unsel_hold", rd_data, last_rd);
        bus_read(4'h4);
        bus_read(4'h0);

        // Randomized mix
        for (int n = 0; n < 120; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3)      send_byte(8'($urandom), 0);
            else if (r == 4) send_byte(8'($urandom), 1);
            else if (r <= 7) bus_read(4'h0);
            else if (r == 8) bus_read(4'h4);
            else             bus_write(4'h8, ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h2);
        end
        bus_read(4'h4);

        // Reset in the middle of TAKE
        send_byte(8'h9E, 0);
        bus_read(4'h4);
        tick;
        rx_ready = 1'b1; rx_data = 8'hAB;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (rx_ack) break;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'h0, rx_ack}, 32'h0);
        check("midrst_rd_data", rd_data, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        mq.delete(); movr = 1'b0; last_rd = 32'h0;
        rx_ready = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        bus_read(4'h4);
        tick; tick;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
